maindec_mc: RTL

//   Multicycle main control unit for the LEGv8 core. Parametrised successor of the

---
 rtl/maindec_mc.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/maindec_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : maindec_mc                                                      |
// | Purpose  : LEGv8 multicycle main control: static decode plus a             |
// |            FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,      |
// |            wait-state timeout and illegal-opcode trap.                     |
// | Option   : MAINDEC_CBNZ_B_EN enables the CBNZ and B instruction classes.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module maindec_mc #(
  parameter int OP_W        = 11,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [OP_W-1:0] Op,
  input  logic            imem_ack,
  input  logic            dmem_ack,
  output logic            imem_req,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            Reg2Loc,
  output logic            ALUSrc,
  output logic            MemtoReg,
  output logic [1:0]      ALUOp,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic            BranchNZ,
  output logic            UncondBranch,
  output logic            Trap,
  output logic [1:0]      TrapCause
);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_fetch  = 3'd1;
  localparam logic [2:0] c_decode = 3'd2;
  localparam logic [2:0] c_exec   = 3'd3;
  localparam logic [2:0] c_mem    = 3'd4;
  localparam logic [2:0] c_wb     = 3'd5;
  localparam logic [2:0] c_trap   = 3'd6;

  localparam logic [2:0] c_cls_none  = 3'd0;
  localparam logic [2:0] c_cls_ldur  = 3'd1;
  localparam logic [2:0] c_cls_stur  = 3'd2;
  localparam logic [2:0] c_cls_cbz   = 3'd3;
  localparam logic [2:0] c_cls_rtype = 3'd4;
  localparam logic [2:0] c_cls_imm   = 3'd5;
`ifdef MAINDEC_CBNZ_B_EN
  localparam logic [2:0] c_cls_cbnz  = 3'd6;
  localparam logic [2:0] c_cls_b     = 3'd7;
`endif

  localparam logic [1:0] c_cause_none    = 2'b00;
  localparam logic [1:0] c_cause_illegal = 2'b01;
  localparam logic [1:0] c_cause_timeout = 2'b10;

  localparam bit               c_tmo_en   = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;

  function automatic logic [2:0] classify(input logic [10:0] op);
    logic [2:0] cls;
    cls = c_cls_none;
    casez (op)
      11'b11111000010: cls = c_cls_ldur;
      11'b11111000000: cls = c_cls_stur;
      11'b10110100???: cls = c_cls_cbz;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls = c_cls_rtype;
      11'b1001000100?,
      11'b1101000100?,
      11'b1001001000?,
      11'b1011001000?,
      11'b110100101??: cls = c_cls_imm;
`ifdef MAINDEC_CBNZ_B_EN
      11'b10110101???: cls = c_cls_cbnz;
      11'b000101?????: cls = c_cls_b;
`endif
      default:         cls = c_cls_none;
    endcase
    return cls;
  endfunction

  logic [2:0]       r_state;
  logic [2:0]       w_nxt;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_op_q;
  logic [2:0]       w_cls;
  logic             w_active;
  logic             w_tmo;
  logic             w_wait;
  logic [2:0]       w_boundary;

  // Op is only valid during DECODE; afterwards the latched copy drives decode.
  assign w_cls      = (r_state == c_decode) ? classify(Op[OP_W-1 -: 11])
                                            : classify(r_op_q[OP_W-1 -: 11]);
  assign w_active   = (r_state == c_decode) || (r_state == c_exec) ||
                      (r_state == c_mem)    || (r_state == c_wb);
  assign w_tmo      = c_tmo_en && (r_cnt == c_cnt_last);
  assign w_wait     = ((r_state == c_fetch) && !imem_ack) ||
                      ((r_state == c_mem)   && !dmem_ack);
  assign w_boundary = run ? c_fetch : c_idle;

  always_comb begin
    w_nxt       = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      c_idle:   w_nxt = run ? c_fetch : c_idle;
      c_fetch: begin
        if (imem_ack) begin
          w_nxt = c_decode;
        end else if (w_tmo) begin
          w_nxt       = c_trap;
          w_cause_nxt = c_cause_timeout;
        end
      end
      c_decode: begin
        if (w_cls == c_cls_none) begin
          w_nxt       = c_trap;
          w_cause_nxt = c_cause_illegal;
        end else begin
          w_nxt = c_exec;
        end
      end
      c_exec: begin
        if ((w_cls == c_cls_ldur) || (w_cls == c_cls_stur))
          w_nxt = c_mem;
        else if ((w_cls == c_cls_rtype) || (w_cls == c_cls_imm))
          w_nxt = c_wb;
        else
          w_nxt = w_boundary;
      end
      c_mem: begin
        if (dmem_ack) begin
          w_nxt = (w_cls == c_cls_ldur) ? c_wb : w_boundary;
        end else if (w_tmo) begin
          w_nxt       = c_trap;
          w_cause_nxt = c_cause_timeout;
        end
      end
      c_wb:     w_nxt = w_boundary;
      c_trap:   w_nxt = c_trap;
      default:  w_nxt = c_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_idle;
      r_cause <= c_cause_none;
      r_cnt   <= '0;
      r_op_q  <= '0;
    end else begin
      r_state <= w_nxt;
      r_cause <= w_cause_nxt;
      if (r_state == c_decode)
        r_op_q <= Op;
      // Counter is zero outside a wait, so entry to FETCH/MEM always starts at 0.
      if (w_wait)
        r_cnt <= (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    ALUOp    = 2'b00;
    if (w_active) begin
      case (w_cls)
        c_cls_ldur:  begin ALUSrc = 1'b1; MemtoReg = 1'b1; end
        c_cls_stur:  begin Reg2Loc = 1'b1; ALUSrc = 1'b1; end
        c_cls_cbz:   begin Reg2Loc = 1'b1; ALUOp = 2'b01; end
        c_cls_rtype: ALUOp = 2'b10;
        c_cls_imm:   begin ALUSrc = 1'b1; ALUOp = 2'b11; end
`ifdef MAINDEC_CBNZ_B_EN
        c_cls_cbnz:  begin Reg2Loc = 1'b1; ALUOp = 2'b01; end
`endif
        default:     ALUOp = 2'b00;
      endcase
    end
  end

  assign imem_req  = (r_state == c_fetch);
  assign IRWrite   = imem_req & imem_ack;
  assign PCWrite   = imem_req & imem_ack;
  assign RegWrite  = (r_state == c_wb);
  assign MemRead   = (r_state == c_mem) && (w_cls == c_cls_ldur);
  assign MemWrite  = (r_state == c_mem) && (w_cls == c_cls_stur);
  assign Branch    = (r_state == c_exec) && (w_cls == c_cls_cbz);
  assign Trap      = (r_state == c_trap);
  assign TrapCause = r_cause;

`ifdef MAINDEC_CBNZ_B_EN
  assign BranchNZ     = (r_state == c_exec) && (w_cls == c_cls_cbnz);
  assign UncondBranch = (r_state == c_exec) && (w_cls == c_cls_b);
`else
  assign BranchNZ     = 1'b0;
  assign UncondBranch = 1'b0;
`endif

endmodule
`default_nettype wire
